// File: rtl/count_sequence_checker.sv
// Receive-side checker for up/down counter buses: acquires the count direction,
// then verifies each later sample against the predicted next value.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no reference sample yet; first valid sample becomes prev
// ST_ACQUIRE | counting consecutive same-direction +/-1 steps toward lock
// ST_LOCKED  | direction known; each sample checked against expected
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     sample,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 direction,
  output logic [WIDTH-1:0]     expected,
  output logic                 seq_error,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [RUN_W-1:0]     LOCK_TGT = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
  localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0]     ALL_ONES = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run_len;
  logic             cand;

  logic [WIDTH-1:0] delta;
  logic             step_up;
  logic             step_dn;
  logic [RUN_W-1:0] run_nxt;
  logic             cand_nxt;
  logic             lock_now;
  logic [WIDTH-1:0] lock_expected;
  logic             match;
  logic [WIDTH-1:0] expected_adv;
  logic             wrap_hit;
  logic             err_inc;

  // Step classification and the acquisition run bookkeeping for this sample.
  always_comb begin
    delta    = sample - prev;
    step_up  = (delta == ONE);
    step_dn  = (delta == ALL_ONES) && !step_up;
    run_nxt  = '0;
    cand_nxt = cand;
    if (step_up) begin
      cand_nxt = 1'b1;
      run_nxt  = (run_len == '0 || cand) ? run_len + RUN_ONE : RUN_ONE;
    end else if (step_dn) begin
      cand_nxt = 1'b0;
      run_nxt  = (run_len == '0 || !cand) ? run_len + RUN_ONE : RUN_ONE;
    end
    lock_now      = (run_nxt == LOCK_TGT);
    lock_expected = cand_nxt ? sample + ONE : sample - ONE;
    match         = (sample == expected);
    expected_adv  = direction ? sample + ONE : sample - ONE;
    wrap_hit      = direction ? (sample == '0) : (sample == ALL_ONES);
    err_inc       = sample_valid && (state == ST_LOCKED) && !match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prev      <= '0;
      run_len   <= '0;
      cand      <= 1'b0;
      locked    <= 1'b0;
      direction <= 1'b0;
      expected  <= '0;
      seq_error <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      seq_error <= 1'b0;
      wrap      <= 1'b0;

      if (sample_valid) begin
        case (state)
          ST_IDLE: begin
            prev    <= sample;
            run_len <= '0;
            state   <= ST_ACQUIRE;
          end

          ST_ACQUIRE: begin
            prev <= sample;
            cand <= cand_nxt;
            if (lock_now) begin
              state     <= ST_LOCKED;
              locked    <= 1'b1;
              direction <= cand_nxt;
              expected  <= lock_expected;
              run_len   <= '0;
            end else begin
              run_len <= run_nxt;
            end
          end

          ST_LOCKED: begin
            prev <= sample;
            if (match) begin
              expected <= expected_adv;
              wrap     <= wrap_hit;
            end else begin
              // direction is left as-is; it is only meaningful while locked
              seq_error <= 1'b1;
              locked    <= 1'b0;
              expected  <= '0;
              run_len   <= '0;
              state     <= ST_ACQUIRE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end

      // Clear wins over a coincident mismatch.
      if (clear_err) begin
        err_count <= '0;
      end else if (err_inc && err_count != ERR_MAX) begin
        err_count <= err_count + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Scoreboard bench for count_sequence_checker: directed scenarios plus random
// counter traffic, compared against a step-history reference model.
module tb_count_sequence_checker;

  localparam int W    = 4;
  localparam int M    = 16;
  localparam int LC   = 3;
  localparam int EW   = 2;
  localparam int EMAX = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  sample = '0;
  logic          clear_err = 1'b0;
  logic          locked;
  logic          direction;
  logic [W-1:0]  expected;
  logic          seq_error;
  logic          wrap;
  logic [EW-1:0] err_count;

  count_sequence_checker #(
    .WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .clear_err(clear_err), .locked(locked), .direction(direction),
    .expected(expected), .seq_error(seq_error), .wrap(wrap),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lk;
    logic          dir;
    logic [W-1:0]  ex;
    logic          se;
    logic          wr;
    logic [EW-1:0] ec;
  } resp_t;

  resp_t scb[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: 0 idle, 1 acquiring, 2 locked. Lock happens when the
  // last LC steps since acquisition (re)started are all the same +/-1.
  int m_state = 0, m_prev = 0, m_dir = 0, m_exp = 0, m_err = 0;
  bit m_seq = 0, m_wrap = 0;
  int m_hist[$];

  function automatic void model_step(bit v, int s, bit clr, bit rst);
    int d, st;
    bit same;
    m_seq  = 0;
    m_wrap = 0;
    if (rst) begin
      m_state = 0; m_prev = 0; m_dir = 0; m_exp = 0; m_err = 0;
      m_hist.delete();
      return;
    end
    if (v) begin
      case (m_state)
        0: begin
          m_prev = s;
          m_hist.delete();
          m_state = 1;
        end
        1: begin
          d = (s - m_prev + M) % M;
          st = (d == 1) ? 1 : ((d == M - 1) ? -1 : 0);
          m_prev = s;
          if (st == 0) m_hist.delete();
          else begin
            m_hist.push_back(st);
            if (m_hist.size() > LC) void'(m_hist.pop_front());
          end
          if (m_hist.size() == LC) begin
            same = 1;
            foreach (m_hist[i]) if (m_hist[i] != st) same = 0;
            if (same) begin
              m_state = 2;
              m_dir = (st > 0) ? 1 : 0;
              m_exp = (s + st + M) % M;
              m_hist.delete();
            end
          end
        end
        default: begin
          if (s == m_exp) begin
            m_wrap = (m_dir == 1) ? (s == 0) : (s == M - 1);
            m_exp = (s + ((m_dir == 1) ? 1 : -1) + M) % M;
            m_prev = s;
          end else begin
            m_seq = 1;
            if (m_err < EMAX) m_err++;
            m_state = 1;
            m_exp = 0;
            m_prev = s;
            m_hist.delete();
          end
        end
      endcase
    end
    if (clr) m_err = 0;
  endfunction

  function automatic resp_t model_resp();
    resp_t r;
    r.lk  = (m_state == 2);
    r.dir = (m_dir == 1);
    r.ex  = W'(m_exp);
    r.se  = m_seq;
    r.wr  = m_wrap;
    r.ec  = EW'(m_err);
    return r;
  endfunction

  task automatic drive(input bit v, input int s, input bit clr, input bit rst);
    @(negedge clk);
    sample_valid = v;
    sample       = W'(s);
    clear_err    = clr;
    reset        = rst;
    model_step(v, s % M, clr, rst);
    scb.push_back(model_resp());
  endtask

  task automatic send(input int s);
    drive(1'b1, s % M, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Monitor: every edge the DUT presents a fresh registered response.
  initial begin
    resp_t got, want;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (scb.size() > 0) begin
        want = scb.pop_front();
        got  = {locked, direction, expected, seq_error, wrap, err_count};
        checks++;
        if (got !== want)  begin
          errors++;
          $display("FAIL resp cycle %0d got lk=%b dir=%b exp=%0d se=%b wr=%b ec=%0d want lk=%b dir=%b exp=%0d se=%b wr=%b ec=%0d",
                   cycle, got.lk, got.dir, got.ex, got.se, got.wr, got.ec,
                   want.lk, want.dir, want.ex, want.se, want.wr, want.ec);
        end
      end
    end
  end

  initial begin
    int y, bad, src, sdir, s, guard;
    bit v, clr, rst;

    do_reset();
    // up lock, then wrap
    for (int i = 0; i < 4; i++) send(i);
    for (int i = 4; i < 16; i++) send(i);
    send(0);
    // error and relock
    for (int i = 1; i < 6; i++) send(i);
    send(9);
    send(10); send(11); send(12);
    drive(1'b0, 7, 1'b0, 1'b0);
    send(13);
    // down lock through wrap, then wrap while locked
    do_reset();
    send(2); send(1); send(0); send(15);
    for (int i = 14; i >= 0; i--) send(i);
    send(15);
    // reversal restarts the run
    do_reset();
    send(5); send(6); send(5); send(4); send(3);
    // saturation then clear with coincident mismatch
    do_reset();
    send(0);
    y = 0;
    for (int k = 0; k < 6; k++) begin
      send(y + 1); send(y + 2); send(y + 3);
      bad = (y + 3 + 5) % M;
      drive(1'b1, bad, (k == 5), 1'b0);
      y = bad;
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    // stall mismatch, then reset with a valid sample
    do_reset();
    send(0); send(1); send(2); send(3);
    send(3);
    send(4); send(5); send(6); send(7);
    drive(1'b1, 9, 1'b0, 1'b1);
    send(10); send(11);

    // random counter traffic with glitches, gaps, clears and resets
    src  = $urandom_range(0, M - 1);
    sdir = 1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      s   = src;
      if ($urandom_range(0, 15) == 0) s = $urandom_range(0, M - 1);
      else if ($urandom_range(0, 24) == 0) sdir = -sdir;
      drive(v, s, clr, rst);
      if (v) src = (src + sdir + M) % M;
    end
    drive(1'b0, 0, 1'b0, 1'b0);

    guard = 0;
    while (scb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending responses want 0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
